// File: rtl/pb_key_if.sv
// Key handshake between the pushbutton front end (producer) and the calculator core.
interface pb_key_if #(
    parameter int CODE_W = 4
) ();
    logic              key_valid;
    logic              key_ready;
    logic [CODE_W-1:0] key_code;

    modport master (output key_valid, output key_code, input key_ready);
    modport slave  (input key_valid, input key_code, output key_ready);
endinterface

// File: rtl/pb_key_encoder.sv
// Pushbutton conditioner: 2-flop sync, tick-sampled debounce, press-edge priority
// encode and a one-entry valid/ready key buffer with a sticky overflow flag.
module pb_key_encoder #(
    parameter int NUM_PB       = 10,
    parameter int TICK_DIV     = 1000,
    parameter int STABLE_TICKS = 4,
    parameter int CODE_W       = 4
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic [NUM_PB-1:0] pb,
    input  logic              ovf_clr,
    output logic [NUM_PB-1:0] pb_level,
    output logic              overflow,
    pb_key_if.master          key
);
    localparam int TW = $clog2(TICK_DIV);
    localparam int CW = $clog2(STABLE_TICKS + 1);

    typedef enum logic {IDLE, PEND} state_t;

    logic [NUM_PB-1:0] sync_p0, sync_p1;
    logic [TW-1:0]     tick_cnt;
    logic              tick;
    logic [CW-1:0]     cnt     [NUM_PB];
    logic [CW-1:0]     cnt_nxt [NUM_PB];
    logic [NUM_PB-1:0] level_nxt;
    logic [NUM_PB-1:0] press_p1;
    logic              any_press, multi_press, drop;
    logic [CODE_W-1:0] sel;
    state_t            state;
    logic              key_valid_r;
    logic [CODE_W-1:0] key_code_r;

    function automatic logic [CODE_W-1:0] lowest_index(input logic [NUM_PB-1:0] v);
        lowest_index = '0;
        for (int i = NUM_PB - 1; i >= 0; i--) begin
            if (v[i]) lowest_index = CODE_W'(i);
        end
    endfunction

    assign tick = (tick_cnt == TW'(TICK_DIV - 1));

    always_comb begin
        level_nxt = pb_level;
        cnt_nxt   = cnt;
        if (tick) begin
            for (int i = 0; i < NUM_PB; i++) begin
                if (sync_p1[i] == pb_level[i]) begin
                    cnt_nxt[i] = '0;
                end else if (cnt[i] == CW'(STABLE_TICKS - 1)) begin
                    level_nxt[i] = sync_p1[i];
                    cnt_nxt[i]   = '0;
                end else begin
                    cnt_nxt[i] = cnt[i] + CW'(1);
                end
            end
        end
    end

    // Stage p0/p1: synchroniser, tick divider, debounce and registered press edges
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            sync_p0  <= '0;
            sync_p1  <= '0;
            tick_cnt <= '0;
            pb_level <= '0;
            press_p1 <= '0;
            for (int i = 0; i < NUM_PB; i++) cnt[i] <= '0;
        end else begin
            sync_p0  <= pb;
            sync_p1  <= sync_p0;
            tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
            pb_level <= level_nxt;
            press_p1 <= level_nxt & ~pb_level;
            for (int i = 0; i < NUM_PB; i++) cnt[i] <= cnt_nxt[i];
        end
    end

    assign any_press   = |press_p1;
    assign multi_press = (press_p1 & (press_p1 - NUM_PB'(1))) != '0;
    assign sel         = lowest_index(press_p1);
    assign drop        = (state == PEND) && !key.key_ready && any_press;

    // Stage p2: key buffer; a press arriving while a key is held and not taken is lost
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state       <= IDLE;
            key_valid_r <= 1'b0;
            key_code_r  <= '0;
            overflow    <= 1'b0;
        end else begin
            if (multi_press || drop) overflow <= 1'b1;
            else if (ovf_clr)        overflow <= 1'b0;

            case (state)
                IDLE: begin
                    if (any_press) begin
                        key_code_r  <= sel;
                        state       <= PEND;
                        key_valid_r <= 1'b1;
                    end
                end
                PEND: begin
                    if (key.key_ready) begin
                        if (any_press) begin
                            key_code_r <= sel;
                        end else begin
                            state       <= IDLE;
                            key_valid_r <= 1'b0;
                        end
                    end
                end
                default: begin
                    state       <= IDLE;
                    key_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign key.key_valid = key_valid_r;
    assign key.key_code  = key_code_r;
endmodule

// File: tb/tb_pb_key_encoder.sv
// Directed bench for pb_key_encoder with TICK_DIV=4, STABLE_TICKS=3.
module tb_pb_key_encoder;
    localparam int NUM_PB = 10;

    logic              clk  = 1'b0;
    logic              nrst = 1'b1;
    logic [NUM_PB-1:0] pb   = '0;
    logic              ovf_clr = 1'b0;
    logic [NUM_PB-1:0] pb_level;
    logic              overflow;

    pb_key_if #(.CODE_W(4)) kif ();

    pb_key_encoder #(
        .NUM_PB(NUM_PB), .TICK_DIV(4), .STABLE_TICKS(3), .CODE_W(4)
    ) dut (
        .clk      (clk),
        .nrst     (nrst),
        .pb       (pb),
        .ovf_clr  (ovf_clr),
        .pb_level (pb_level),
        .overflow (overflow),
        .key      (kif)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int xfers = 0;

    always @(posedge clk) begin
        if (kif.key_valid && kif.key_ready) xfers <= xfers + 1;
    end

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic wait_valid(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            step(1);
            if (kif.key_valid) ok = 1'b1;
        end
    endtask

    task automatic wait_level(input int idx, input bit val, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            step(1);
            if (pb_level[idx] == val) ok = 1'b1;
        end
    endtask

    initial begin
        int x0;
        bit ok;
        bit seen;

        kif.key_ready = 1'b1;
        pb = 10'b00_0010_0000;
        #2 nrst = 1'b0;
        step(3);
        chk("rst_valid", int'(kif.key_valid), 0);
        chk("rst_code",  int'(kif.key_code), 0);
        chk("rst_level", int'(pb_level), 0);
        chk("rst_ovf",   int'(overflow), 0);

        // clean press of pb[5], held from reset release
        nrst = 1'b1;
        x0 = xfers;
        step(11);
        chk("clean_level_e11", int'(pb_level[5]), 0);
        step(1);
        chk("clean_level_e12", int'(pb_level[5]), 1);
        chk("clean_valid_e12", int'(kif.key_valid), 0);
        step(1);
        chk("clean_valid_e13", int'(kif.key_valid), 1);
        chk("clean_code",      int'(kif.key_code), 5);
        step(1);
        chk("clean_valid_e14", int'(kif.key_valid), 0);
        chk("clean_xfers",     xfers - x0, 1);
        pb = '0;
        wait_level(5, 1'b0, 20, ok);
        chk("release_level", int'(ok), 1);
        step(4);
        chk("release_no_key", xfers - x0, 1);
        chk("release_valid",  int'(kif.key_valid), 0);

        // bounce on pb[2]
        x0 = xfers;
        seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (c % 3 == 0) pb[2] = ~pb[2];
            step(1);
            if (pb_level[2] || kif.key_valid) seen = 1'b1;
        end
        pb = '0;
        for (int c = 0; c < 20; c++) begin
            step(1);
            if (pb_level[2] || kif.key_valid) seen = 1'b1;
        end
        chk("bounce_seen",  int'(seen), 0);
        chk("bounce_xfers", xfers - x0, 0);
        chk("bounce_ovf",   int'(overflow), 0);

        // simultaneous press of pb[7] and pb[3]
        x0 = xfers;
        pb = 10'b00_1000_1000;
        wait_valid(40, ok);
        chk("simul_valid", int'(ok), 1);
        chk("simul_code",  int'(kif.key_code), 3);
        chk("simul_ovf",   int'(overflow), 1);
        step(3);
        chk("simul_valid_drop", int'(kif.key_valid), 0);
        chk("simul_xfers",      xfers - x0, 1);
        ovf_clr = 1'b1;
        step(1);
        ovf_clr = 1'b0;
        chk("simul_ovf_clr", int'(overflow), 0);
        pb = '0;
        step(20);

        // backpressure: pb[1] held in the buffer, pb[4] dropped
        kif.key_ready = 1'b0;
        pb[1] = 1'b1;
        wait_valid(40, ok);
        chk("bp_valid", int'(ok), 1);
        chk("bp_code",  int'(kif.key_code), 1);
        pb[1] = 1'b0;
        wait_level(1, 1'b0, 20, ok);
        chk("bp_release", int'(ok), 1);
        chk("bp_ovf_pre", int'(overflow), 0);
        pb[4] = 1'b1;
        wait_level(4, 1'b1, 20, ok);
        chk("bp_level4", int'(ok), 1);
        step(2);
        chk("bp_valid_hold", int'(kif.key_valid), 1);
        chk("bp_code_hold",  int'(kif.key_code), 1);
        chk("bp_ovf",        int'(overflow), 1);
        kif.key_ready = 1'b1;
        step(1);
        kif.key_ready = 1'b0;
        chk("bp_valid_after", int'(kif.key_valid), 0);
        kif.key_ready = 1'b1;
        ovf_clr = 1'b1;
        step(1);
        ovf_clr = 1'b0;
        pb = '0;
        step(20);

        // back-to-back: ready coincides with a new press while pending
        kif.key_ready = 1'b0;
        pb[6] = 1'b1;
        wait_valid(40, ok);
        chk("b2b_valid", int'(ok), 1);
        chk("b2b_code6", int'(kif.key_code), 6);
        pb[8] = 1'b1;
        wait_level(8, 1'b1, 20, ok);
        chk("b2b_level8", int'(ok), 1);
        kif.key_ready = 1'b1;
        step(1);
        kif.key_ready = 1'b0;
        chk("b2b_valid_stay", int'(kif.key_valid), 1);
        chk("b2b_code8",      int'(kif.key_code), 8);
        chk("b2b_ovf",        int'(overflow), 0);
        step(2);
        chk("b2b_code_stable", int'(kif.key_code), 8);
        kif.key_ready = 1'b1;
        step(1);
        chk("b2b_valid_end", int'(kif.key_valid), 0);
        pb = '0;
        step(20);

        // asynchronous reset with key 9 pending and overflow set
        kif.key_ready = 1'b0;
        pb[9] = 1'b1;
        wait_valid(40, ok);
        chk("ar_valid", int'(ok), 1);
        chk("ar_code9", int'(kif.key_code), 9);
        pb[0] = 1'b1;
        wait_level(0, 1'b1, 20, ok);
        step(2);
        chk("ar_ovf_pre", int'(overflow), 1);
        #3 nrst = 1'b0;
        #1;
        chk("ar_valid_rst", int'(kif.key_valid), 0);
        chk("ar_code_rst",  int'(kif.key_code), 0);
        chk("ar_level_rst", int'(pb_level), 0);
        chk("ar_ovf_rst",   int'(overflow), 0);
        pb = '0;
        #8 nrst = 1'b1;
        kif.key_ready = 1'b1;
        x0 = xfers;
        seen = 1'b0;
        for (int c = 0; c < 30; c++) begin
            step(1);
            if (kif.key_valid) seen = 1'b1;
        end
        chk("ar_no_key",   int'(seen), 0);
        chk("ar_no_xfers", xfers - x0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/pb_key_encoder.md
Name: pb_key_encoder

Overview:
Front-end input conditioner for the calculator. It takes raw breakout-board pushbuttons and runs each one through a two-flop synchroniser and a tick-sampled debouncer. It detects press (rising) edges, priority-encodes them into a key code and presents each code to the calculator core through a one-entry valid/ready buffer. It is the producer side of the pushbutton interface that the calculator consumes, and it sits between the gpio_in pins and the calculator core.

Parameters:
NUM_PB, 10, number of pushbuttons (1..16).
TICK_DIV, 1000, clock cycles per debounce sample tick (>=2).
STABLE_TICKS, 4, consecutive ticks a new level must persist before it is accepted (>=1).
CODE_W, 4, key code width; must satisfy 2**CODE_W >= NUM_PB.

Ports:
clk  input  1  system clock; all logic on rising edge.
nrst  input  1  asynchronous active-low reset.
pb  input  NUM_PB  raw pushbutton levels, asynchronous, active-high.
key_ready  input  1  consumer accepts key_code this cycle.
ovf_clr  input  1  synchronous clear of overflow.
key_valid  output  1  key_code holds an unconsumed press.
key_code  output  CODE_W  index of the pressed button.
pb_level  output  NUM_PB  debounced button levels.
overflow  output  1  sticky flag: at least one press was dropped.

Behaviour:
- Reset: one clock (clk); reset is asynchronous and active-low (nrst). While nrst=0, all flops clear immediately: synchronisers, tick counter, per-button counters, pb_level, key_valid, key_code, overflow, and FSM=IDLE. Reset asserted mid-handshake discards the pending key.
- Synchroniser: pb passes through 2 flops per bit to give sync[i].
- Tick counter: counts 0..TICK_DIV-1 and wraps to 0.
  - tick=1 only in the cycle where count==TICK_DIV-1.
  - After reset release, the first tick occurs in cycle TICK_DIV-1.
- Per-button debounce: counter cnt[i], updated only on tick cycles.
  - If sync[i]==pb_level[i]: cnt[i]<=0.
  - Else if cnt[i]==STABLE_TICKS-1: pb_level[i]<=sync[i], cnt[i]<=0.
  - Else: cnt[i]<=cnt[i]+1.
  - Any bounce back to the old level on a tick restarts the count.
- Press event: press[i] is 1 for the single cycle in which pb_level[i] transitions 0->1, derived from the pb_level flop input vs. output. Releases (1->0) generate no event.
- Encoder: when any press bit is set, sel = lowest set index.
  - If more than one bit is set in the same cycle, the higher-index presses are dropped and overflow<=1.
- Output FSM, states IDLE and PEND; key_valid=1 exactly in PEND.
  - IDLE, event: key_code<=sel, go to PEND. key_valid rises one clock after the edge on which pb_level rises.
  - IDLE, no event: stay; key_code holds its last value.
  - PEND, key_ready=1 and event: key_code<=sel, stay in PEND (back-to-back transfer, no overflow).
  - PEND, key_ready=1 and no event: go to IDLE.
  - PEND, key_ready=0 and event: the new press is dropped, overflow<=1, key_code unchanged.
  - key_code is stable whenever key_valid=1 and key_ready=0.
- Overflow: cleared by ovf_clr=1. If a set condition and ovf_clr coincide in the same cycle, set wins.
- Latency: with pb held stable high from cycle t, pb_level rises no later than t+2+STABLE_TICKS*TICK_DIV. key_valid follows one cycle later.
- Width rule: key_code = sel zero-extended to CODE_W.
- Counter widths:
  - cnt[i]: clog2(STABLE_TICKS+1) bits.
  - Tick counter: clog2(TICK_DIV) bits.

Test Plan:
Config for all scenarios: TICK_DIV=4, STABLE_TICKS=3, key_ready=1 unless noted.
- Clean press: pb[5]=1 held from reset release. Expect:
  - pb_level[5]=1 by cycle 15.
  - key_valid=1 for exactly 1 cycle with key_code=5.
  - Release: pb_level[5]->0 with no new key_valid.
- Bounce rejection: toggle pb[2] every 3 cycles for 40 cycles, then hold at 0. Expect pb_level[2]=0 throughout, key_valid never asserts, overflow=0.
- Simultaneous press: pb[7] and pb[3] rise in the same cycle and are held. Expect:
  - key_code=3 with a single key_valid.
  - overflow=1.
  - ovf_clr pulse -> overflow=0 next cycle.
- Backpressure: key_ready=0; press pb[1], release it, then press pb[4]. Expect:
  - key_valid stays high with key_code=1.
  - pb[4] press dropped, overflow=1.
  - key_ready=1 for one cycle -> key_valid=0 next cycle.
- Back-to-back: key_ready asserted in the same cycle as a new press event while in PEND. Expect key_valid to stay high, key_code to update to the new index, and overflow=0.
- Reset mid-operation: key_valid=1 with key_code=9; drive nrst=0 for 1 cycle, asynchronously to clk. Expect key_valid, key_code, pb_level and overflow all 0 immediately, and no key reported after release while pb is low.
